// File: rtl/encoder_pkg.sv
// Shared helpers for the one-hot encoder: lowest-set-bit index, one-hot test and the S2 payload type.
// Words narrower than MAX_N are zero-extended by the caller.
package encoder_pkg;

    localparam int unsigned MAX_N = 64;
    localparam int unsigned MAX_W = 6;

    typedef struct packed {
        logic [MAX_W-1:0] idx;
        logic             err;
    } enc_payload_t;

    // Scans from the top so the last hit is the lowest set bit; all-zero yields 0.
    function automatic logic [MAX_W-1:0] onehot_lowest_idx(input logic [MAX_N-1:0] code);
        logic [MAX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (code[i]) idx = MAX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [MAX_N-1:0] code);
        return ($countones(code) == 1);
    endfunction

endpackage

// File: rtl/onehot_enc_core.sv
// Combinational one-hot to binary encode, sitting between the S1 and S2 registers.
module onehot_enc_core
    import encoder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] code_i,
    output enc_payload_t enc_o
);

    logic [MAX_N-1:0] code_ext;

    always_comb begin
        code_ext  = MAX_N'(code_i);
        enc_o     = '0;
        enc_o.idx = onehot_lowest_idx(code_ext);
        enc_o.err = !is_onehot(code_ext);
    end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Two-stage one-hot to binary encoder with valid/ready handshake and a saturating error counter.
module onehot_encoder_pipe
    import encoder_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = $clog2(N),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_idx,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_cnt
);

    logic             s1_v_q, s1_v_d;
    logic [N-1:0]     s1_code_q, s1_code_d;
    logic             s2_v_q, s2_v_d;
    enc_payload_t     s2_q, s2_d, enc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s2_load, out_xfer;

    onehot_enc_core #(.N(N)) u_core (
        .code_i (s1_code_q),
        .enc_o  (enc)
    );

    // Whenever S1 may accept while holding a word, S2 is loading, so S1 never overwrites.
    always_comb begin
        s2_load   = !s2_v_q || out_ready;
        in_ready  = !s1_v_q || s2_load;
        out_xfer  = s2_v_q && out_ready;

        s1_v_d    = s1_v_q;
        s1_code_d = s1_code_q;
        if (in_ready) begin
            s1_v_d = in_valid;
            if (in_valid) s1_code_d = in_code;
        end

        s2_v_d = s2_v_q;
        s2_d   = s2_q;
        if (s2_load) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) s2_d = enc;
        end

        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_xfer && s2_q.err && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_code_q <= '0;
            s2_v_q    <= 1'b0;
            s2_q      <= '0;
            cnt_q     <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_code_q <= s1_code_d;
            s2_v_q    <= s2_v_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_idx   = W'(s2_q.idx);
    assign out_err   = s2_q.err;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Scoreboard bench for onehot_encoder_pipe (N=4): directed scenarios followed by random traffic.
module tb_onehot_encoder_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_idx;
    logic       out_err;
    logic [7:0] err_cnt;
    logic       clr_cnt;

    onehot_encoder_pipe #(.N(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_err   (out_err),
        .err_cnt   (err_cnt),
        .clr_cnt   (clr_cnt)
    );

    typedef struct {
        int idx;
        bit err;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   seen[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   exp_cnt  = 0;
    bit   lat_chk  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: lowest set bit position, error when the popcount is not exactly one.
    function automatic exp_t ref_encode(input logic [3:0] code, input int c);
        exp_t e;
        int   ones;
        ones  = 0;
        e.idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (((code >> i) & 4'd1) != 0) begin
                ones++;
                if (e.idx < 0) e.idx = i;
            end
        end
        if (e.idx < 0) e.idx = 0;
        e.err = (ones != 1);
        e.cyc = c;
        return e;
    endfunction

    // Monitor: everything sampled at negedge equals what the next posedge will see.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            bit   err_xfer;
            err_xfer = 0;
            chk("err_cnt", int'(err_cnt), exp_cnt);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_idx", int'(out_idx), e.idx);
                    chk("out_err", int'(out_err), int'(e.err));
                    if (lat_chk) chk("latency", cyc - e.cyc, 2);
                    seen.push_back(int'(out_idx));
                    err_xfer = e.err;
                end
            end
            if (in_valid && in_ready) q.push_back(ref_encode(in_code, cyc));
            if (clr_cnt) exp_cnt = 0;
            else if (err_xfer && exp_cnt < 255) exp_cnt++;
        end
    end

    task automatic send(input logic [3:0] c);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_code  = c;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] codes[4];
        int         n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Streaming one-hot words, fixed two-cycle latency.
        out_ready = 1'b1;
        lat_chk   = 1;
        codes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        seen.delete();
        for (int i = 0; i < 4; i++) send(codes[i]);
        drain();
        chk("stream_count", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("stream_order", seen[i], i);
        chk("stream_err_cnt", int'(err_cnt), 0);

        // Not one-hot inputs.
        send(4'b0000);
        send(4'b0110);
        drain();
        chk("err_two", int'(err_cnt), 2);
        lat_chk = 0;

        // Backpressure: two words fill the pipe, third is held by the source.
        out_ready = 1'b0;
        seen.delete();
        send(4'b0100);
        send(4'b1000);
        in_valid = 1'b1;
        in_code  = 4'b0001;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", int'(in_ready), 0);
            chk("full_out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        chk("bp_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("bp_first", seen[0], 2);
            chk("bp_second", seen[1], 3);
            chk("bp_third", seen[2], 0);
        end

        // Saturation, then clear coinciding with an error transfer.
        for (int i = 0; i < 300; i++) send(4'b1100);
        drain();
        chk("sat_err_cnt", int'(err_cnt), 255);
        send(4'b1100);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("clr_wait_out_valid", int'(out_valid), 1);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_err_cnt", int'(err_cnt), 0);

        // Reset with a full, stalled pipe; held words must never appear.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(4'b0001);
        send(4'b0010);
        in_valid = 1'b1;
        in_code  = 4'b0100;
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", int'(out_valid), 1);
        chk("pre_rst_in_ready", int'(in_ready), 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_idx", int'(out_idx), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        q.delete();
        exp_cnt  = 0;
        in_valid = 1'b0;
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_idle", int'(out_valid), 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_code   = ($urandom_range(0, 1) != 0) ? (4'b0001 << $urandom_range(0, 3))
                                                    : 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt   = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        clr_cnt   = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
